// File: rtl/vfx_pkg.sv
// rtl/vfx_pkg.sv - shared types and frame geometry for the VFX pixel pipeline
package vfx_pkg;

    typedef logic [11:0] pixel_t;

    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        BLANK
    } reader_state_t;

    // Counter width for n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// rtl/pixel_coord_counter.sv - raster col/row counter with last-column and last-pixel flags
module pixel_coord_counter
    import vfx_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int COL_W  = clog2_min1(WIDTH),
    parameter int ROW_W  = clog2_min1(HEIGHT)
) (
    input  logic             clk,       // block clock
    input  logic             rst_n,     // asynchronous active-low reset
    input  logic             clr,       // return to (0,0); wins over step
    input  logic             step,      // advance one pixel in raster order
    output logic [COL_W-1:0] col,       // current column
    output logic [ROW_W-1:0] row,       // current row
    output logic             last_col,  // col is WIDTH-1
    output logic             last_pix   // col/row is the final pixel of the frame
);

    assign last_col = (col == COL_W'(WIDTH - 1));
    assign last_pix = last_col && (row == ROW_W'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_stream_reader.sv
// rtl/frame_stream_reader.sv - frame-buffer raster reader driving the pixel stream (option macro: FRAME_READER_TEST_PATTERN_EN)
module frame_stream_reader
    import vfx_pkg::*;
#(
    parameter int IMG_WIDTH    = vfx_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT   = vfx_pkg::IMG_HEIGHT,
    parameter int PIX_W        = 12,
    parameter int ADDR_W       = 17,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,          // block clock
    input  logic              rst_n,        // asynchronous active-low reset
    input  logic              start,        // begin one frame, honoured only in IDLE
`ifdef FRAME_READER_TEST_PATTERN_EN
    input  logic              test_pattern, // generate pattern instead of reading RAM
`endif
    input  logic              continuous,   // chain the next frame at the end of BLANK
    output logic              fb_rd_en,     // frame-buffer read enable
    output logic [ADDR_W-1:0] fb_rd_addr,   // row*IMG_WIDTH+col
    input  logic [PIX_W-1:0]  fb_rd_data,   // read data, one cycle after the address
    output logic              ready_out,    // pixel valid, high for one whole frame
    output logic [PIX_W-1:0]  data_out,     // pixel, zero while ready_out is low
    output logic              sof,          // pixel (0,0)
    output logic              eol,          // last pixel of a row
    output logic              eof,          // last pixel of the frame
    output logic              busy          // any state other than IDLE
);

    localparam int COL_W = clog2_min1(IMG_WIDTH);
    localparam int ROW_W = clog2_min1(IMG_HEIGHT);

    reader_state_t    state;
    logic             iss;        // read slot being issued this cycle
    logic             rd_vld;     // fb_rd_data carries a frame pixel this cycle
    logic [7:0]       blank_cnt;
    logic             blank_done;
    logic             enter_prime;
    logic [PIX_W-1:0] pixel_src;

    logic [COL_W-1:0] ag_col, oc_col;
    logic [ROW_W-1:0] ag_row, oc_row;
    logic             ag_last_col, ag_last_pix;
    logic             oc_last_col, oc_last_pix;
    logic             ag_step;

    assign blank_done  = (blank_cnt == 8'(BLANK_CYCLES - 1));
    assign enter_prime = ((state == IDLE) && start) ||
                         ((state == BLANK) && blank_done && continuous);
    // The address counter parks on the final pixel once it has been issued.
    assign ag_step     = (state == STREAM) && iss && !ag_last_pix;
    assign fb_rd_addr  = ADDR_W'(ag_row * IMG_WIDTH + ag_col);

    // Address side: tracks the pixel presented on fb_rd_addr.
    pixel_coord_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_addr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (enter_prime),
        .step     (ag_step),
        .col      (ag_col),
        .row      (ag_row),
        .last_col (ag_last_col),
        .last_pix (ag_last_pix)
    );

    // Output side: tracks the pixel about to be loaded into the output register,
    // i.e. the address counter delayed by the RAM stage.
    pixel_coord_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (enter_prime),
        .step     (rd_vld),
        .col      (oc_col),
        .row      (oc_row),
        .last_col (oc_last_col),
        .last_pix (oc_last_pix)
    );

`ifdef FRAME_READER_TEST_PATTERN_EN
    logic        tp_mode;
    logic [3:0]  frame_count;
    logic [15:0] col_x;
    logic [15:0] row_x;
    pixel_t      pattern;

    assign col_x     = 16'(oc_col);
    assign row_x     = 16'(oc_row);
    assign pattern   = {col_x[8:5], row_x[7:4], frame_count};
    assign pixel_src = tp_mode ? PIX_W'(pattern) : fb_rd_data;
    assign fb_rd_en  = iss && !tp_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_mode     <= 1'b0;
            frame_count <= 4'd0;
        end else begin
            if (enter_prime) begin
                tp_mode <= test_pattern;
            end
            if (rd_vld && oc_last_pix) begin
                frame_count <= frame_count + 4'd1;
            end
        end
    end
`else
    assign pixel_src = fb_rd_data;
    assign fb_rd_en  = iss;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            iss       <= 1'b0;
            rd_vld    <= 1'b0;
            blank_cnt <= 8'd0;
            ready_out <= 1'b0;
            data_out  <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            rd_vld    <= iss;
            ready_out <= rd_vld;
            data_out  <= rd_vld ? pixel_src : '0;
            sof       <= rd_vld && (oc_col == '0) && (oc_row == '0);
            eol       <= rd_vld && oc_last_col;
            eof       <= rd_vld && oc_last_pix;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PRIME;
                        busy  <= 1'b1;
                    end
                end
                PRIME: begin
                    iss   <= 1'b1;
                    state <= STREAM;
                end
                STREAM: begin
                    if (iss && ag_last_pix) begin
                        iss <= 1'b0;
                    end
                    // Leave once the final pixel enters the output register.
                    if (rd_vld && oc_last_pix) begin
                        state     <= BLANK;
                        blank_cnt <= 8'd0;
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        if (continuous) begin
                            state <= PRIME;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_reader.sv
// tb/tb_frame_stream_reader.sv - self-checking bench for frame_stream_reader
module tb_frame_stream_reader;

    localparam int W  = 20;
    localparam int H  = 6;
    localparam int P  = W * H;
    localparam int AW = 7;
    localparam int B  = 5;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          continuous;
    logic          fb_rd_en;
    logic [AW-1:0] fb_rd_addr;
    logic [PW-1:0] fb_rd_data = '0;
    logic          ready_out;
    logic [PW-1:0] data_out;
    logic          sof, eol, eof, busy;
`ifdef FRAME_READER_TEST_PATTERN_EN
    logic          test_pattern = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
    end

    frame_stream_reader #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .PIX_W        (PW),
        .ADDR_W       (AW),
        .BLANK_CYCLES (B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef FRAME_READER_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .continuous   (continuous),
        .fb_rd_en     (fb_rd_en),
        .fb_rd_addr   (fb_rd_addr),
        .fb_rd_data   (fb_rd_data),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .sof          (sof),
        .eol          (eol),
        .eof          (eof),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({fb_rd_en, fb_rd_addr, ready_out, data_out, sof, eol, eof, busy});
    endfunction

    // Checks pixels 0..stop-1 on consecutive cycles against memory order and
    // index-derived flags; pulses start at index poke.
    task automatic expect_frame(input int poke, input int stop, output int eols);
        logic [15:0] e;
        eols = 0;
        for (int idx = 0; idx < stop; idx++) begin
            start = (idx == poke);
            e = {1'b1, idx == 0, (idx % W) == W - 1, idx == P - 1, mem[idx]};
            check($sformatf("pix%0d", idx), 32'({ready_out, sof, eol, eof, data_out}), 32'(e));
            if (eol) eols++;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic pulse_start_and_wait(input string tag);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!ready_out && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, lat, 3);
    endtask

    initial begin
        int eols, bz, lo, seen, poke, rp;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = PW'($urandom);

        repeat (3) tick();
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_outputs", all_outputs(), 32'd0);

        // Single frame; a start re-pulse mid-frame must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_no_read_yet", 32'({busy, fb_rd_en}), 32'(2'b10));
        tick();
        check("prime_addr0", 32'({fb_rd_en, fb_rd_addr}), 32'({1'b1, AW'(0)}));
        bz = 1;
        while (!ready_out && bz < 20) begin
            tick();
            bz++;
        end
        check("first_latency", bz, 3);
        poke = $urandom_range(1, P - 2);
        expect_frame(poke, P, eols);
        check("eol_count", eols, H);
        check("ready_low_after", 32'({ready_out, data_out}), 32'd0);
        bz = 0;
        while (busy && bz < 100) begin
            tick();
            bz++;
        end
        check("busy_drop", bz, B - 1);
        seen = 0;
        repeat (P + 2 * B + 10) begin
            tick();
            if (ready_out || busy || fb_rd_en) seen = 1;
        end
        check("no_queued_frame", seen, 0);

        // Continuous: two back-to-back frames, then stop.
        continuous = 1'b1;
        pulse_start_and_wait("cont_latency");
        expect_frame(-1, P, eols);
        lo = 0;
        while (!ready_out && lo < 100) begin
            tick();
            lo++;
        end
        check("blank_gap", lo, B + 2);
        continuous = 1'b0;
        expect_frame(-1, P, eols);
        check("eol_count2", eols, H);
        bz = 0;
        while (busy && bz < 100) begin
            tick();
            bz++;
        end
        check("busy_drop2", bz, B - 1);

        // Reset mid-frame, then a fresh frame from pixel 0.
        pulse_start_and_wait("rst_latency");
        rp = $urandom_range(2, P - 2);
        expect_frame(-1, rp, eols);
        rst_n = 1'b0;
        #1;
        check("reset_midframe", all_outputs(), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after_reset_idle", all_outputs(), 32'd0);
        pulse_start_and_wait("restart_latency");
        expect_frame(-1, P, eols);
        check("eol_count3", eols, H);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
